// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control unit: opcodes, ALU codes, select
// encodings, the control word layout, branch FSM states and word builders.
package ctrl_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00001;
  localparam logic [4:0] OP_SUB   = 5'b00010;
  localparam logic [4:0] OP_SUBI  = 5'b00011;
  localparam logic [4:0] OP_CMP   = 5'b00100;
  localparam logic [4:0] OP_CMPI  = 5'b00101;
  localparam logic [4:0] OP_AND   = 5'b00110;
  localparam logic [4:0] OP_OR    = 5'b00111;
  localparam logic [4:0] OP_NOT   = 5'b01000;
  localparam logic [4:0] OP_XOR   = 5'b01001;
  localparam logic [4:0] OP_LD    = 5'b01010;
  localparam logic [4:0] OP_LDA   = 5'b01011;
  localparam logic [4:0] OP_ST    = 5'b01100;
  localparam logic [4:0] OP_STA   = 5'b01101;
  localparam logic [4:0] OP_MOV   = 5'b01110;
  localparam logic [4:0] OP_MOVA  = 5'b01111;
  localparam logic [4:0] OP_SLL   = 5'b10000;
  localparam logic [4:0] OP_JMP   = 5'b10011;
  localparam logic [4:0] OP_BNE   = 5'b10100;
  localparam logic [4:0] OP_BEQ   = 5'b10101;
  localparam logic [4:0] OP_MUL   = 5'b10110;
  localparam logic [4:0] OP_NOP   = 5'b10111;
  localparam logic [4:0] OP_ADDV  = 5'b11000;
  localparam logic [4:0] OP_ADDVI = 5'b11001;
  localparam logic [4:0] OP_XORV  = 5'b11010;
  localparam logic [4:0] OP_SLLV  = 5'b11011;
  localparam logic [4:0] OP_SRLV  = 5'b11100;
  localparam logic [4:0] OP_SLLVC = 5'b11101;
  localparam logic [4:0] OP_SRLVC = 5'b11110;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_XOR   = 4'b0010;
  localparam logic [3:0] ALU_ADD   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_CMP   = 4'b0101;
  localparam logic [3:0] ALU_NOT   = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_MUL   = 4'b1000;
  localparam logic [3:0] ALU_SRLV  = 4'b1001;
  localparam logic [3:0] ALU_SLLV  = 4'b1010;
  localparam logic [3:0] ALU_SLLVC = 4'b1011;
  localparam logic [3:0] ALU_SRLVC = 4'b1100;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_ALU  = 2'b10;
  localparam logic [1:0] RES_MEM  = 2'b11;

  typedef struct packed {
    logic [1:0] pcSel;
    logic       selDirRegB;
    logic       muxValA;
    logic       muxValB;
    logic [3:0] aluCode;
    logic [1:0] resultSel;
    logic       dirWriteSel;
    logic       dirMemSel;
    logic       datoSel;
    logic       writeMem;
    logic       writeReg;
    logic       flush;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    BR_WAIT    = 2'd1,
    BR_RESOLVE = 2'd2
  } state_t;

  // Idle word: matches the reset value of the output register.
  function automatic ctrl_word_t bubbleWord();
    ctrl_word_t w;
    w           = '0;
    w.dirMemSel = 1'b1;
    return w;
  endfunction

  function automatic ctrl_word_t aluWord(input logic [3:0] code, input logic imm);
    ctrl_word_t w;
    w           = '0;
    w.aluCode   = code;
    w.resultSel = RES_ALU;
    w.dirMemSel = 1'b1;
    w.datoSel   = 1'b1;
    w.writeReg  = 1'b1;
    w.muxValB   = imm;
    return w;
  endfunction

  function automatic ctrl_word_t resolveWord(input logic taken);
    ctrl_word_t w;
    w       = bubbleWord();
    w.pcSel = taken ? PC_BRANCH : PC_SEQ;
    w.flush = taken;
    return w;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: builds the control word for one opcode and
// classifies it as branch, vector or illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output ctrl_word_t     word,
  output logic           isBranch,
  output logic           isBeq,
  output logic           isVector,
  output logic           illegal
);

  logic [4:0] op5S;
  logic       highBitsS;
  logic       caseIllegalS;

  // Table lookup of the control word; anything wider than five bits is illegal.
  always_comb begin
    op5S         = opcode[4:0];
    highBitsS    = (opcode >> 3'd5) != '0;
    word         = '0;
    caseIllegalS = 1'b0;
    isBranch     = 1'b0;
    isBeq        = 1'b0;
    case (op5S)
      OP_ADD:   word = aluWord(ALU_ADD, 1'b0);
      OP_ADDI:  word = aluWord(ALU_ADD, 1'b1);
      OP_SUB:   word = aluWord(ALU_SUB, 1'b0);
      OP_SUBI:  word = aluWord(ALU_SUB, 1'b1);
      OP_CMP:   word = aluWord(ALU_CMP, 1'b0);
      OP_CMPI:  word = aluWord(ALU_CMP, 1'b1);
      OP_AND:   word = aluWord(ALU_AND, 1'b0);
      OP_OR:    word = aluWord(ALU_OR, 1'b0);
      OP_NOT:   word = aluWord(ALU_NOT, 1'b0);
      OP_XOR:   word = aluWord(ALU_XOR, 1'b0);
      OP_SLL:   word = aluWord(ALU_SLL, 1'b0);
      OP_MUL:   word = aluWord(ALU_MUL, 1'b0);
      OP_ADDV:  word = aluWord(ALU_ADD, 1'b0);
      OP_ADDVI: word = aluWord(ALU_ADD, 1'b1);
      OP_XORV:  word = aluWord(ALU_XOR, 1'b0);
      OP_SLLV:  word = aluWord(ALU_SLLV, 1'b0);
      OP_SRLV:  word = aluWord(ALU_SRLV, 1'b0);
      OP_SLLVC: word = aluWord(ALU_SLLVC, 1'b0);
      OP_SRLVC: word = aluWord(ALU_SRLVC, 1'b0);
      OP_LD, OP_LDA: begin
        word.resultSel = RES_MEM;
        word.writeReg  = 1'b1;
        word.muxValA   = op5S[0];
      end
      OP_ST, OP_STA: begin
        word.selDirRegB = 1'b1;
        word.dirMemSel  = 1'b1;
        word.writeMem   = 1'b1;
        word.muxValA    = op5S[0];
      end
      OP_MOV, OP_MOVA: begin
        word.dirMemSel = 1'b1;
        word.datoSel   = 1'b1;
        word.writeReg  = 1'b1;
        word.muxValA   = op5S[0];
      end
      OP_NOP: begin
        word.resultSel   = RES_MEM;
        word.dirWriteSel = 1'b1;
        word.dirMemSel   = 1'b1;
        word.datoSel     = 1'b1;
      end
      OP_JMP: begin
        word.pcSel = PC_JUMP;
        word.flush = 1'b1;
      end
      OP_BNE, OP_BEQ: begin
        word.aluCode    = ALU_CMP;
        word.selDirRegB = 1'b1;
        word.dirMemSel  = 1'b1;
        word.datoSel    = 1'b1;
        isBranch        = 1'b1;
        isBeq           = op5S[0];
      end
      default: caseIllegalS = 1'b1;
    endcase
    if (highBitsS) begin
      word     = '0;
      isBranch = 1'b0;
      isBeq    = 1'b0;
      illegal  = 1'b1;
    end else begin
      illegal  = caseIllegalS;
    end
    isVector = (op5S[4:3] == 2'b11) & ~illegal;
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Registered pipeline control unit: decodes accepted opcodes into a control word,
// resolves conditional branches on EX flags and drives fetch stall / flush.
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int OPW        = 5,
  parameter int ALUW       = 4,
  parameter int NUM_LANES  = 4,
  parameter int BR_TIMEOUT = 8,
  localparam int VLW       = $clog2(NUM_LANES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 instr_valid,
  input  logic [OPW-1:0]       opcode,
  input  logic [VLW-1:0]       vl,
  input  logic [1:0]           flags,
  input  logic                 flags_valid,
  input  logic                 stall_in,
  output logic                 instr_ready,
  output logic                 ctrl_valid,
  output logic [1:0]           pc_sel,
  output logic                 sel_dir_reg_b,
  output logic                 mux_val_a,
  output logic                 mux_val_b,
  output logic [ALUW-1:0]      alu_code,
  output logic [1:0]           result_sel,
  output logic                 dir_write_sel,
  output logic                 dir_mem_sel,
  output logic                 dato_sel,
  output logic                 write_mem,
  output logic                 write_reg,
  output logic [NUM_LANES-1:0] lane_mask,
  output logic                 fetch_stall,
  output logic                 flush,
  output logic                 illegal_op,
  output logic                 br_timeout
);

  localparam int CNTW = $clog2(BR_TIMEOUT + 1);

  state_t               stateR, nextStateS;
  logic [CNTW-1:0]      cntR, nextCntS;
  logic                 isBeqR, nextIsBeqS;
  logic                 takenR, nextTakenS;
  logic                 timedOutR, nextTimedOutS;
  logic                 issuedR, nextIssuedS;

  ctrl_word_t           wordR, newWordS, decWordS;
  logic                 validR, newValidS;
  logic [NUM_LANES-1:0] maskR, newMaskS;
  logic                 fetchStallR, newFetchStallS;
  logic                 illegalR, newIllegalS;
  logic                 timeoutR, newTimeoutS;
  logic                 loadS;

  logic decBranchS, decBeqS, decVectorS, decIllegalS;
  logic instrReadyS, acceptS, flagsTakenS, timeoutHitS;

  function automatic logic [NUM_LANES-1:0] laneMaskFor(input logic [VLW-1:0] len);
    logic [NUM_LANES-1:0] m;
    for (int i = 0; i < NUM_LANES; i++) begin
      m[i] = (int'(len) > i);
    end
    return m;
  endfunction

  ctrl_decode #(.OPW(OPW)) uDecode (
    .opcode   (opcode),
    .word     (decWordS),
    .isBranch (decBranchS),
    .isBeq    (decBeqS),
    .isVector (decVectorS),
    .illegal  (decIllegalS)
  );

  assign instrReadyS = (stateR == RUN) & ~stall_in & ~reset;
  assign acceptS     = instr_valid & instrReadyS;
  assign flagsTakenS = isBeqR ? (flags == 2'b01) : (flags != 2'b01);
  assign timeoutHitS = (cntR == CNTW'(BR_TIMEOUT - 1));

  // Next state, branch bookkeeping and the word to load into the output register.
  always_comb begin
    nextStateS     = stateR;
    nextCntS       = cntR;
    nextIsBeqS     = isBeqR;
    nextTakenS     = takenR;
    nextTimedOutS  = timedOutR;
    nextIssuedS    = issuedR;
    loadS          = 1'b0;
    newWordS       = bubbleWord();
    newValidS      = 1'b0;
    newMaskS       = '0;
    newFetchStallS = 1'b0;
    newIllegalS    = 1'b0;
    newTimeoutS    = 1'b0;
    case (stateR)
      RUN: begin
        loadS = ~stall_in;
        if (acceptS && decIllegalS) begin
          newIllegalS = 1'b1;
        end else if (acceptS) begin
          newWordS  = decWordS;
          newValidS = 1'b1;
          newMaskS  = decVectorS ? laneMaskFor(vl) : '0;
          if (decBranchS) begin
            nextStateS     = BR_WAIT;
            nextCntS       = '0;
            nextIsBeqS     = decBeqS;
            nextTakenS     = 1'b0;
            nextTimedOutS  = 1'b0;
            nextIssuedS    = 1'b0;
            newFetchStallS = 1'b1;
          end else begin
            nextStateS = RUN;
          end
        end else begin
          newValidS = 1'b0;
        end
      end
      BR_WAIT: begin
        nextCntS = cntR + CNTW'(1);
        // Flags are latched even under stall; the redirect word waits for stall to drop.
        if (flags_valid || timeoutHitS) begin
          nextStateS    = BR_RESOLVE;
          nextTakenS    = flags_valid & flagsTakenS;
          nextTimedOutS = ~flags_valid;
          nextIssuedS   = ~stall_in;
          loadS         = ~stall_in;
          newWordS      = resolveWord(flags_valid & flagsTakenS);
          newTimeoutS   = ~flags_valid;
        end else begin
          loadS          = ~stall_in;
          newFetchStallS = 1'b1;
        end
      end
      BR_RESOLVE: begin
        loadS = ~stall_in;
        if (issuedR) begin
          nextStateS  = stall_in ? BR_RESOLVE : RUN;
          nextIssuedS = stall_in;
        end else begin
          newWordS    = resolveWord(takenR);
          newTimeoutS = timedOutR;
          nextIssuedS = ~stall_in;
        end
      end
      default: begin
        nextStateS = RUN;
      end
    endcase
  end

  // State, branch bookkeeping and the registered output word.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR      <= RUN;
      cntR        <= '0;
      isBeqR      <= 1'b0;
      takenR      <= 1'b0;
      timedOutR   <= 1'b0;
      issuedR     <= 1'b0;
      wordR       <= bubbleWord();
      validR      <= 1'b0;
      maskR       <= '0;
      fetchStallR <= 1'b0;
      illegalR    <= 1'b0;
      timeoutR    <= 1'b0;
    end else begin
      stateR    <= nextStateS;
      cntR      <= nextCntS;
      isBeqR    <= nextIsBeqS;
      takenR    <= nextTakenS;
      timedOutR <= nextTimedOutS;
      issuedR   <= nextIssuedS;
      if (loadS) begin
        wordR       <= newWordS;
        validR      <= newValidS;
        maskR       <= newMaskS;
        fetchStallR <= newFetchStallS;
        illegalR    <= newIllegalS;
        timeoutR    <= newTimeoutS;
      end
    end
  end

  assign instr_ready   = instrReadyS;
  assign ctrl_valid    = validR;
  assign pc_sel        = wordR.pcSel;
  assign sel_dir_reg_b = wordR.selDirRegB;
  assign mux_val_a     = wordR.muxValA;
  assign mux_val_b     = wordR.muxValB;
  assign alu_code      = ALUW'(wordR.aluCode);
  assign result_sel    = wordR.resultSel;
  assign dir_write_sel = wordR.dirWriteSel;
  assign dir_mem_sel   = wordR.dirMemSel;
  assign dato_sel      = wordR.datoSel;
  assign write_mem     = wordR.writeMem;
  assign write_reg     = wordR.writeReg;
  assign lane_mask     = maskR;
  assign fetch_stall   = fetchStallR;
  assign flush         = wordR.flush;
  assign illegal_op    = illegalR;
  assign br_timeout    = timeoutR;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Self-checking bench for pipe_control_unit: directed scenarios followed by
// randomized traffic, compared each cycle against a behavioural model.
module tb_pipe_control_unit;

  typedef struct packed {
    logic       ctrlValid;
    logic [1:0] pcSel;
    logic       selDirRegB;
    logic       muxValA;
    logic       muxValB;
    logic [3:0] aluCode;
    logic [1:0] resultSel;
    logic       dirWriteSel;
    logic       dirMemSel;
    logic       datoSel;
    logic       writeMem;
    logic       writeReg;
    logic [3:0] laneMask;
    logic       fetchStall;
    logic       flush;
    logic       illegalOp;
    logic       brTimeout;
  } obs_t;

  logic clk = 1'b0;
  logic reset, instr_valid, flags_valid, stall_in;
  logic [4:0] opcode;
  logic [2:0] vl;
  logic [1:0] flags;
  logic instr_ready, ctrl_valid, sel_dir_reg_b, mux_val_a, mux_val_b;
  logic dir_write_sel, dir_mem_sel, dato_sel, write_mem, write_reg;
  logic fetch_stall, flush, illegal_op, br_timeout;
  logic [1:0] pc_sel, result_sel;
  logic [3:0] alu_code, lane_mask;

  int checks = 0;
  int failures = 0;

  obs_t dutObs, expObs;
  bit   brActive, brIsBeq, brDecided, brTaken, brTimedOut, brShown;
  int   brCycles;

  always #5 clk = ~clk;

  pipe_control_unit dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode), .vl(vl),
    .flags(flags), .flags_valid(flags_valid), .stall_in(stall_in),
    .instr_ready(instr_ready), .ctrl_valid(ctrl_valid), .pc_sel(pc_sel),
    .sel_dir_reg_b(sel_dir_reg_b), .mux_val_a(mux_val_a), .mux_val_b(mux_val_b),
    .alu_code(alu_code), .result_sel(result_sel), .dir_write_sel(dir_write_sel),
    .dir_mem_sel(dir_mem_sel), .dato_sel(dato_sel), .write_mem(write_mem),
    .write_reg(write_reg), .lane_mask(lane_mask), .fetch_stall(fetch_stall),
    .flush(flush), .illegal_op(illegal_op), .br_timeout(br_timeout)
  );

  always_comb begin
    dutObs             = '0;
    dutObs.ctrlValid   = ctrl_valid;
    dutObs.pcSel       = pc_sel;
    dutObs.selDirRegB  = sel_dir_reg_b;
    dutObs.muxValA     = mux_val_a;
    dutObs.muxValB     = mux_val_b;
    dutObs.aluCode     = alu_code;
    dutObs.resultSel   = result_sel;
    dutObs.dirWriteSel = dir_write_sel;
    dutObs.dirMemSel   = dir_mem_sel;
    dutObs.datoSel     = dato_sel;
    dutObs.writeMem    = write_mem;
    dutObs.writeReg    = write_reg;
    dutObs.laneMask    = lane_mask;
    dutObs.fetchStall  = fetch_stall;
    dutObs.flush       = flush;
    dutObs.illegalOp   = illegal_op;
    dutObs.brTimeout   = br_timeout;
  end

  function automatic obs_t bubbleObs();
    obs_t o;
    o = '0;
    o.dirMemSel = 1'b1;
    return o;
  endfunction

  function automatic obs_t aluObs(input logic [3:0] code, input logic imm);
    obs_t o;
    o = '0;
    o.ctrlValid = 1'b1;
    o.aluCode   = code;
    o.resultSel = 2'b10;
    o.dirMemSel = 1'b1;
    o.datoSel   = 1'b1;
    o.writeReg  = 1'b1;
    o.muxValB   = imm;
    return o;
  endfunction

  // Expected output word for an accepted opcode, straight from the opcode table.
  function automatic obs_t decodeObs(input logic [4:0] op, input logic [2:0] len);
    obs_t o;
    int lanes;
    o = '0;
    o.ctrlValid = 1'b1;
    case (op)
      5'b00000: o = aluObs(4'b0011, 1'b0);
      5'b00001: o = aluObs(4'b0011, 1'b1);
      5'b00010: o = aluObs(4'b0100, 1'b0);
      5'b00011: o = aluObs(4'b0100, 1'b1);
      5'b00100: o = aluObs(4'b0101, 1'b0);
      5'b00101: o = aluObs(4'b0101, 1'b1);
      5'b00110: o = aluObs(4'b0000, 1'b0);
      5'b00111: o = aluObs(4'b0001, 1'b0);
      5'b01000: o = aluObs(4'b0110, 1'b0);
      5'b01001: o = aluObs(4'b0010, 1'b0);
      5'b10000: o = aluObs(4'b0111, 1'b0);
      5'b10110: o = aluObs(4'b1000, 1'b0);
      5'b11000: o = aluObs(4'b0011, 1'b0);
      5'b11001: o = aluObs(4'b0011, 1'b1);
      5'b11010: o = aluObs(4'b0010, 1'b0);
      5'b11011: o = aluObs(4'b1010, 1'b0);
      5'b11100: o = aluObs(4'b1001, 1'b0);
      5'b11101: o = aluObs(4'b1011, 1'b0);
      5'b11110: o = aluObs(4'b1100, 1'b0);
      5'b01010, 5'b01011: begin
        o.resultSel = 2'b11; o.writeReg = 1'b1; o.muxValA = (op == 5'b01011);
      end
      5'b01100, 5'b01101: begin
        o.selDirRegB = 1'b1; o.dirMemSel = 1'b1; o.writeMem = 1'b1; o.muxValA = (op == 5'b01101);
      end
      5'b01110, 5'b01111: begin
        o.dirMemSel = 1'b1; o.datoSel = 1'b1; o.writeReg = 1'b1; o.muxValA = (op == 5'b01111);
      end
      5'b10111: begin
        o.resultSel = 2'b11; o.dirWriteSel = 1'b1; o.dirMemSel = 1'b1; o.datoSel = 1'b1;
      end
      5'b10011: begin
        o.pcSel = 2'b01; o.flush = 1'b1;
      end
      5'b10100, 5'b10101: begin
        o.aluCode = 4'b0101; o.selDirRegB = 1'b1; o.dirMemSel = 1'b1; o.datoSel = 1'b1;
        o.fetchStall = 1'b1;
      end
      default: begin
        o = bubbleObs(); o.illegalOp = 1'b1;
      end
    endcase
    if (op[4:3] == 2'b11 && op != 5'b11111) begin
      lanes = (len > 3'd4) ? 4 : int'(len);
      o.laneMask = 4'((1 << lanes) - 1);
    end
    return o;
  endfunction

  function automatic obs_t redirectObs(input bit taken, input bit timedOut);
    obs_t o;
    o = bubbleObs();
    o.pcSel     = taken ? 2'b10 : 2'b00;
    o.flush     = taken;
    o.brTimeout = timedOut;
    return o;
  endfunction

  // Advance the reference by one clock using the currently driven inputs.
  task automatic modelStep();
    if (reset) begin
      expObs   = bubbleObs();
      brActive = 1'b0;
    end else if (!brActive) begin
      if (!stall_in) begin
        expObs = instr_valid ? decodeObs(opcode, vl) : bubbleObs();
        if (instr_valid && (opcode == 5'b10100 || opcode == 5'b10101)) begin
          brActive  = 1'b1;
          brIsBeq   = (opcode == 5'b10101);
          brCycles  = 0;
          brDecided = 1'b0;
          brShown   = 1'b0;
        end
      end
    end else if (!brDecided) begin
      brCycles++;
      if (flags_valid || brCycles == 8) begin
        brDecided  = 1'b1;
        brTimedOut = !flags_valid;
        brTaken    = flags_valid && (brIsBeq ? (flags == 2'b01) : (flags != 2'b01));
        if (!stall_in) begin
          expObs  = redirectObs(brTaken, brTimedOut);
          brShown = 1'b1;
        end
      end else if (!stall_in) begin
        expObs = bubbleObs();
        expObs.fetchStall = 1'b1;
      end
    end else if (!stall_in) begin
      if (!brShown) begin
        expObs  = redirectObs(brTaken, brTimedOut);
        brShown = 1'b1;
      end else begin
        expObs   = bubbleObs();
        brActive = 1'b0;
      end
    end
  endtask

  task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkObs(input string tag);
    checks++;
    assert (dutObs === expObs) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, dutObs, expObs);
    end
  endtask

  task automatic tick(input string tag);
    logic expReady;
    #1;
    expReady = !brActive && !stall_in && !reset;
    chkVal({tag, "_ready"}, 32'(instr_ready), 32'(expReady));
    modelStep();
    @(posedge clk);
    #1;
    chkObs(tag);
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; opcode = 5'd0; vl = 3'd0;
    flags = 2'b00; flags_valid = 1'b0; stall_in = 1'b0;
    brActive = 1'b0; brIsBeq = 1'b0; brDecided = 1'b0; brTaken = 1'b0;
    brTimedOut = 1'b0; brShown = 1'b0; brCycles = 0; expObs = '0;
    tick("reset0");
    tick("reset1");
    chkVal("rst_dir_mem_sel", 32'(dir_mem_sel), 32'd1);
    chkVal("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
    reset = 1'b0;

    // addi
    instr_valid = 1'b1; opcode = 5'b00001;
    tick("addi");
    chkVal("addi_alu", 32'(alu_code), 32'h3);
    chkVal("addi_mvb", 32'(mux_val_b), 32'd1);
    chkVal("addi_valid", 32'(ctrl_valid), 32'd1);
    instr_valid = 1'b0;
    tick("idle");

    // BEQ taken, flags two cycles after accept
    instr_valid = 1'b1; opcode = 5'b10101;
    tick("beq_T");
    instr_valid = 1'b0;
    tick("beq_T1");
    chkVal("beq_fetch_stall", 32'(fetch_stall), 32'd1);
    flags = 2'b01; flags_valid = 1'b1;
    tick("beq_T2");
    flags_valid = 1'b0;
    chkVal("beq_pc_sel", 32'(pc_sel), 32'h2);
    chkVal("beq_flush", 32'(flush), 32'd1);
    tick("beq_T3");
    chkVal("beq_ready", 32'(instr_ready), 32'd1);

    // BNE equal (not taken) and not equal (taken)
    for (int k = 0; k < 2; k++) begin
      instr_valid = 1'b1; opcode = 5'b10100;
      tick("bne_acc");
      instr_valid = 1'b0; flags = (k == 0) ? 2'b01 : 2'b10; flags_valid = 1'b1;
      tick("bne_flag");
      flags_valid = 1'b0;
      chkVal("bne_pc_sel", 32'(pc_sel), (k == 0) ? 32'h0 : 32'h2);
      chkVal("bne_flush", 32'(flush), (k == 0) ? 32'd0 : 32'd1);
      tick("bne_done");
    end

    // BEQ timeout
    instr_valid = 1'b1; opcode = 5'b10101;
    tick("to_acc");
    instr_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick("to_wait");
    chkVal("to_pulse", 32'(br_timeout), 32'd1);
    chkVal("to_pc_sel", 32'(pc_sel), 32'h0);
    tick("to_after");
    chkVal("to_deassert", 32'(br_timeout), 32'd0);

    // vector lane masks and an illegal opcode
    instr_valid = 1'b1; opcode = 5'b11000; vl = 3'd3;
    tick("addv_vl3");
    chkVal("addv_vl3_mask", 32'(lane_mask), 32'h7);
    vl = 3'd4;
    tick("addv_vl4");
    chkVal("addv_vl4_mask", 32'(lane_mask), 32'hF);
    opcode = 5'b10001;
    tick("illegal");
    chkVal("illegal_pulse", 32'(illegal_op), 32'd1);
    chkVal("illegal_valid", 32'(ctrl_valid), 32'd0);
    instr_valid = 1'b0;
    tick("idle2");

    // stall held across resolve delays the redirect
    instr_valid = 1'b1; opcode = 5'b10101;
    tick("st_acc");
    instr_valid = 1'b0; stall_in = 1'b1; flags = 2'b01; flags_valid = 1'b1;
    tick("st_flag");
    flags_valid = 1'b0;
    tick("st_hold1");
    tick("st_hold2");
    chkVal("st_held_pc_sel", 32'(pc_sel), 32'h0);
    stall_in = 1'b0;
    tick("st_go");
    chkVal("st_pc_sel", 32'(pc_sel), 32'h2);
    tick("st_done");

    // reset during BR_WAIT aborts without redirect
    instr_valid = 1'b1; opcode = 5'b10100;
    tick("rb_acc");
    instr_valid = 1'b0; reset = 1'b1;
    tick("rb_reset");
    reset = 1'b0; flags = 2'b10; flags_valid = 1'b1;
    tick("rb_after");
    flags_valid = 1'b0;
    chkVal("rb_pc_sel", 32'(pc_sel), 32'h0);
    chkVal("rb_fetch_stall", 32'(fetch_stall), 32'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      opcode      = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0) opcode = 5'(5'd20 + 5'($urandom_range(0, 1)));
      vl          = 3'($urandom_range(0, 7));
      flags       = 2'($urandom_range(0, 3));
      flags_valid = ($urandom_range(0, 4) == 0);
      stall_in    = ($urandom_range(0, 4) == 0);
      reset       = ($urandom_range(0, 80) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
